set_bit_scanner_32bits: RTL and testbench



---
 rtl/set_bit_scanner_32bits_pkg.sv | 19 +
 rtl/lowest_set_index_32bits.sv | 43 ++++
 rtl/set_bit_scanner_32bits.sv | 86 ++++++++
 tb/tb_set_bit_scanner_32bits.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/set_bit_scanner_32bits_pkg.sv
// Shared types and constants for the 32-bit set-bit scanner.
// Holds the FSM encoding and the one-hot decode used to clear a scanned bit.
package set_bit_scanner_32bits_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StScan = 2'b01,
        StDone = 2'b10
    } state_t;

    function automatic logic [WIDTH-1:0] onehot(input logic [IDX_W-1:0] idx);
        return WIDTH'(1) << idx;
    endfunction

endpackage

// File: rtl/lowest_set_index_32bits.sv
// Combinational priority encoder: index of the lowest set bit of a 32-bit mask.
// Five-level binary tree; each node prefers its lower half when that half has a set bit.
module lowest_set_index_32bits
    import set_bit_scanner_32bits_pkg::*;
(
    input  logic [WIDTH-1:0] i_mask,
    output logic [IDX_W-1:0] o_index,
    output logic             o_found
);

    logic [15:0]       w_f1;
    logic [15:0]       w_i1;
    logic [7:0]        w_f2;
    logic [7:0][1:0]   w_i2;
    logic [3:0]        w_f3;
    logic [3:0][2:0]   w_i3;
    logic [1:0]        w_f4;
    logic [1:0][3:0]   w_i4;

    for (genvar j = 0; j < 16; j++) begin : g_lvl1
        assign w_f1[j] = i_mask[2*j] | i_mask[2*j+1];
        assign w_i1[j] = ~i_mask[2*j];
    end

    for (genvar j = 0; j < 8; j++) begin : g_lvl2
        assign w_f2[j] = w_f1[2*j] | w_f1[2*j+1];
        assign w_i2[j] = w_f1[2*j] ? {1'b0, w_i1[2*j]} : {1'b1, w_i1[2*j+1]};
    end

    for (genvar j = 0; j < 4; j++) begin : g_lvl3
        assign w_f3[j] = w_f2[2*j] | w_f2[2*j+1];
        assign w_i3[j] = w_f2[2*j] ? {1'b0, w_i2[2*j]} : {1'b1, w_i2[2*j+1]};
    end

    for (genvar j = 0; j < 2; j++) begin : g_lvl4
        assign w_f4[j] = w_f3[2*j] | w_f3[2*j+1];
        assign w_i4[j] = w_f3[2*j] ? {1'b0, w_i3[2*j]} : {1'b1, w_i3[2*j+1]};
    end

    assign o_found = w_f4[0] | w_f4[1];
    assign o_index = w_f4[0] ? {1'b0, w_i4[0]} : {1'b1, w_i4[1]};

endmodule

// File: rtl/set_bit_scanner_32bits.sv
// Walks a captured 32-bit word, handing off each set-bit index LSB-first over a
// valid/ready handshake, then pulses done for one cycle.
module set_bit_scanner_32bits
    import set_bit_scanner_32bits_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_mask, w_mask_next;
    logic [CNT_W-1:0] r_count, w_count_next;
    logic [IDX_W-1:0] w_low_idx;
    logic             w_found;
    logic             w_single;

    lowest_set_index_32bits u_lowest (
        .i_mask  (r_mask),
        .o_index (w_low_idx),
        .o_found (w_found)
    );

    // Exactly one bit left: clearing the lowest bit empties the mask.
    assign w_single = (r_mask & (r_mask - WIDTH'(1))) == '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
            r_mask  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_mask  <= w_mask_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_mask_next  = r_mask;
        w_count_next = r_count;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        out_index    = '0;
        done         = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_mask_next  = data_in;
                    w_count_next = '0;
                    w_state_next = (|data_in) ? StScan : StDone;
                end
            end
            StScan: begin
                out_valid = w_found;
                out_index = w_low_idx;
                out_last  = w_single;
                if (out_ready) begin
                    w_mask_next  = r_mask & ~onehot(w_low_idx);
                    w_count_next = r_count + CNT_W'(1);
                    if (w_single) begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                done         = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign busy  = (r_state != StIdle);
    assign count = r_count;

endmodule

// File: tb/tb_set_bit_scanner_32bits.sv
// Self-checking bench for set_bit_scanner_32bits: directed table, reset-abort
// sequence and randomized words checked against a bit-list reference model.
module tb_set_bit_scanner_32bits;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] data_in;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic        out_last;
    logic        done;
    logic [5:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    set_bit_scanner_32bits dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .done      (done),
        .count     (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one complete scan starting from IDLE; all sampling/driving on negedges.
    task automatic run_scan(input logic [31:0] w, input bit rnd_ready, input bit poke,
                            output int n_out, output int first_idx, output int last_idx);
        int  exp_q[$];
        int  k;
        int  stalls;
        int  cyc;
        bit  seen_done;
        bit  pending;
        for (int b = 0; b < 32; b++) if (w[b]) exp_q.push_back(b);
        k = 0; stalls = 0; cyc = 1; seen_done = 0; pending = 0;
        first_idx = -1; last_idx = -1;
        @(negedge clock);
        chk("idle_before_start", {31'b0, busy}, 32'd0);
        start   = 1'b1;
        data_in = w;
        @(negedge clock);
        start   = 1'b0;
        data_in = $urandom;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        chk("count_cleared", {26'b0, count}, 32'd0);
        while (!seen_done && cyc < 200) begin
            if (pending) chk("valid_held", {31'b0, out_valid}, 32'd1);
            if (out_valid) begin
                if (k < exp_q.size()) begin
                    chk("index", {27'b0, out_index}, exp_q[k]);
                    chk("last", {31'b0, out_last}, (k == exp_q.size() - 1) ? 32'd1 : 32'd0);
                end else begin
                    chk("extra_valid", {31'b0, out_valid}, 32'd0);
                end
                chk("count_live", {26'b0, count}, k);
                if (k == 0) first_idx = out_index;
                last_idx  = out_index;
                out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                start     = poke && ($urandom_range(0, 3) == 0);
                data_in   = $urandom;
                if (out_ready) begin
                    k++;
                    pending = 0;
                end else begin
                    stalls++;
                    pending = 1;
                end
            end else begin
                start = 1'b0;
                if (done) begin
                    seen_done = 1;
                    chk("done_cycle", cyc, exp_q.size() + stalls + 1);
                end else begin
                    chk("no_gap", {31'b0, done}, 32'd1);
                end
            end
            @(negedge clock);
            cyc++;
        end
        chk("done_seen", {31'b0, seen_done}, 32'd1);
        chk("idle_after_done", {31'b0, busy}, 32'd0);
        chk("done_one_cycle", {31'b0, done}, 32'd0);
        chk("count_final", {26'b0, count}, exp_q.size());
        n_out = k;
    endtask

    typedef struct {
        logic [31:0] data;
        bit          rnd;
        bit          poke;
        int          exp_n;
        int          exp_first;
        int          exp_last;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n, f, l;
        logic [31:0] w;

        tbl[0] = '{32'h0000_0000, 1'b0, 1'b0, 0, -1, -1};
        tbl[1] = '{32'h8000_0001, 1'b0, 1'b0, 2, 0, 31};
        tbl[2] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 32, 0, 31};
        tbl[3] = '{32'h0000_0A50, 1'b1, 1'b0, 4, 4, 11};
        tbl[4] = '{32'h0000_0A50, 1'b1, 1'b1, 4, 4, 11};
        tbl[5] = '{32'h0000_0001, 1'b0, 1'b1, 1, 0, 0};
        tbl[6] = '{32'h8000_0000, 1'b1, 1'b0, 1, 31, 31};

        reset = 1'b1; start = 1'b0; data_in = '0; out_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_last", {31'b0, out_last}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_index", {27'b0, out_index}, 32'd0);
        chk("rst_count", {26'b0, count}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_scan(tbl[i].data, tbl[i].rnd, tbl[i].poke, n, f, l);
            chk($sformatf("tbl%0d_n", i), n, tbl[i].exp_n);
            chk($sformatf("tbl%0d_first", i), f, tbl[i].exp_first);
            chk($sformatf("tbl%0d_last", i), l, tbl[i].exp_last);
        end

        // Reset after two of five handshakes aborts without a done pulse.
        @(negedge clock);
        start = 1'b1; data_in = 32'h0001_F000; out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("abort_idx0", {27'b0, out_index}, 32'd12);
        @(negedge clock);
        chk("abort_idx1", {27'b0, out_index}, 32'd13);
        @(negedge clock);
        chk("abort_cnt2", {26'b0, count}, 32'd2);
        reset = 1'b1; start = 1'b1; data_in = $urandom;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_last", {31'b0, out_last}, 32'd0);
        chk("abort_index", {27'b0, out_index}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_count", {26'b0, count}, 32'd0);
        @(negedge clock);
        chk("abort_no_done", {31'b0, done}, 32'd0);
        run_scan(32'h0001_F000, 1'b0, 1'b0, n, f, l);
        chk("rescan_n", n, 5);
        chk("rescan_first", f, 12);
        chk("rescan_last", l, 16);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: w = $urandom;
                1: w = $urandom & $urandom & $urandom;
                2: w = $urandom | $urandom;
                default: w = 32'd1 << $urandom_range(0, 31);
            endcase
            run_scan(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n, f, l);
            chk("rand_n", n, $countones(w));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
